// File: rtl/minirisc_pkg.sv
// minirisc_pkg: shared FSM state encodings, opcode class constants and opcode patterns
package minirisc_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;
  localparam logic [1:0] CLS_R   = 2'b00;
  localparam logic [1:0] CLS_I   = 2'b01;
  localparam logic [1:0] CLS_JAL = 2'b10;
  localparam logic [1:0] CLS_BR  = 2'b11;
  // load = LOAD_PFX then zeros, store = STORE_PFX then zeros, halt = all ones
  localparam logic [1:0] LOAD_PFX  = CLS_I;
  localparam logic [2:0] STORE_PFX = {CLS_I, 1'b1};
endpackage

// File: rtl/opcode_decoder.sv
// opcode_decoder: combinational opcode classification and datapath select bits
// Ports: i_op opcode in; o_cls class; o_is_load/store/halt/illegal/long flags;
//        o_alu_src, o_label_sel, o_jump_sel datapath selects.
module opcode_decoder
  import minirisc_pkg::*;
#(
  parameter int OPW        = 6,
  parameter bit LONG_OP_EN = 1'b1
) (
  input  logic [OPW-1:0] i_op,
  output logic [1:0]     o_cls,
  output logic           o_is_load,
  output logic           o_is_store,
  output logic           o_is_halt,
  output logic           o_is_illegal,
  output logic           o_is_long,
  output logic           o_alu_src,
  output logic           o_label_sel,
  output logic           o_jump_sel
);
  assign o_cls        = i_op[OPW-1:OPW-2];
  assign o_is_load    = i_op == {LOAD_PFX, {(OPW-2){1'b0}}};
  assign o_is_store   = i_op == {STORE_PFX, {(OPW-3){1'b0}}};
  assign o_is_halt    = &i_op;
  assign o_is_illegal = (o_cls == CLS_JAL) && (|i_op[OPW-3:0]);
  assign o_is_long    = LONG_OP_EN && (o_cls == CLS_R) && i_op[0];
  assign o_alu_src    = i_op[OPW-3] | i_op[OPW-4];
  assign o_label_sel  = o_cls == CLS_BR;
  assign o_jump_sel   = ~i_op[OPW-3] & ~i_op[OPW-4];
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: fetch/decode/exec/mem/wb sequencer for the miniRISC core
// Ports: i_clk, i_rst_n (sync, active-low); i_instr_op, i_imem_ack, i_dmem_ack,
//        i_alu_done, i_branch_taken handshakes; o_imem_req/o_dmem_req request levels;
//        o_ir_write/o_pc_write/o_reg_write/o_mem_write/o_mem_read strobes;
//        o_alu_src/o_label_sel/o_jump_sel/o_reg_dest/o_mem_to_reg latched selects;
//        o_halted/o_err sticky status; o_state debug.
module multicycle_control_unit
  import minirisc_pkg::*;
#(
  parameter int OPW        = 6,
  parameter int TIMEOUT    = 16,
  parameter bit LONG_OP_EN = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [OPW-1:0] i_instr_op,
  input  logic           i_imem_ack,
  input  logic           i_dmem_ack,
  input  logic           i_alu_done,
  input  logic           i_branch_taken,
  output logic           o_imem_req,
  output logic           o_dmem_req,
  output logic           o_ir_write,
  output logic           o_pc_write,
  output logic           o_reg_write,
  output logic           o_mem_write,
  output logic           o_mem_read,
  output logic           o_alu_src,
  output logic           o_label_sel,
  output logic           o_jump_sel,
  output logic [1:0]     o_reg_dest,
  output logic [1:0]     o_mem_to_reg,
  output logic           o_halted,
  output logic           o_err,
  output logic [2:0]     o_state
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t         r_state, w_next;
  logic [OPW-1:0] r_op;
  logic [CW-1:0]  r_cnt;
  logic [1:0]     r_cls;
  logic           r_alu_src, r_label_sel, r_jump_sel;
  logic [1:0]     w_cls;
  logic           w_is_load, w_is_store, w_is_halt, w_is_illegal, w_is_long;
  logic           w_alu_src, w_label_sel, w_jump_sel, w_limit;
  // decodes the opcode captured at the fetch handshake; it stays stable for the whole instruction
  opcode_decoder #(.OPW(OPW), .LONG_OP_EN(LONG_OP_EN)) u_dec (
    .i_op        (r_op),
    .o_cls       (w_cls),
    .o_is_load   (w_is_load),
    .o_is_store  (w_is_store),
    .o_is_halt   (w_is_halt),
    .o_is_illegal(w_is_illegal),
    .o_is_long   (w_is_long),
    .o_alu_src   (w_alu_src),
    .o_label_sel (w_label_sel),
    .o_jump_sel  (w_jump_sel)
  );
  // r_cnt counts prior waiting cycles, so this is the TIMEOUT-th cycle; an ack here still wins
  assign w_limit = r_cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge i_clk) begin
    r_state <= !i_rst_n ? S_IDLE : w_next;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_op        <= '0;
      r_cls       <= '0;
      r_alu_src   <= 1'b0;
      r_label_sel <= 1'b0;
      r_jump_sel  <= 1'b0;
    end else begin
      r_cnt <= (w_next == r_state && (r_state == S_FETCH || r_state == S_MEM)) ? r_cnt + 1'b1 : '0;
      if (r_state == S_FETCH && i_imem_ack) r_op <= i_instr_op;
      if (r_state == S_DECODE) begin
        r_cls       <= w_cls;
        r_alu_src   <= w_alu_src;
        r_label_sel <= w_label_sel;
        r_jump_sel  <= w_jump_sel;
      end
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  w_next = i_imem_ack ? S_DECODE : w_limit ? S_ERROR : S_FETCH;
      S_DECODE: w_next = w_is_halt ? S_HALT : w_is_illegal ? S_ERROR : S_EXEC;
      S_EXEC:   w_next = (w_is_long && !i_alu_done) ? S_EXEC :
                         (w_cls == CLS_BR) ? S_FETCH :
                         (w_is_load || w_is_store) ? S_MEM : S_WB;
      S_MEM:    w_next = i_dmem_ack ? (w_is_load ? S_WB : S_FETCH) : w_limit ? S_ERROR : S_MEM;
      S_WB:     w_next = S_FETCH;
      default:  w_next = r_state;
    endcase
  end
  always_comb begin
    o_imem_req   = r_state == S_FETCH;
    o_dmem_req   = r_state == S_MEM;
    o_ir_write   = (r_state == S_FETCH) && i_imem_ack;
    o_pc_write   = ((r_state == S_FETCH) && i_imem_ack) ||
                   ((r_state == S_EXEC) && (w_cls == CLS_BR) && i_branch_taken) ||
                   ((r_state == S_WB) && (w_cls == CLS_JAL));
    o_reg_write  = r_state == S_WB;
    o_mem_write  = (r_state == S_MEM) && w_is_store;
    o_mem_read   = (r_state == S_MEM) && w_is_load;
    o_alu_src    = r_alu_src;
    o_label_sel  = r_label_sel;
    o_jump_sel   = r_jump_sel;
    o_reg_dest   = r_cls;
    o_mem_to_reg = r_cls;
    o_halted     = r_state == S_HALT;
    o_err        = r_state == S_ERROR;
    o_state      = r_state;
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed self-checking bench for the multi-cycle control unit
module tb_multicycle_control_unit;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [5:0] instr_op = '0;
  logic       imem_ack = 1'b0, dmem_ack = 1'b0, alu_done = 1'b0, branch_taken = 1'b0;
  logic       imem_req, dmem_req, ir_write, pc_write, reg_write, mem_write, mem_read;
  logic       alu_src, label_sel, jump_sel, halted, err;
  logic [1:0] reg_dest, mem_to_reg;
  logic [2:0] state;
  int         n_run = 0, n_fail = 0, n_rd;
  always #5 clk = ~clk;
  multicycle_control_unit #(.OPW(6), .TIMEOUT(4), .LONG_OP_EN(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr_op(instr_op), .i_imem_ack(imem_ack),
    .i_dmem_ack(dmem_ack), .i_alu_done(alu_done), .i_branch_taken(branch_taken),
    .o_imem_req(imem_req), .o_dmem_req(dmem_req), .o_ir_write(ir_write), .o_pc_write(pc_write),
    .o_reg_write(reg_write), .o_mem_write(mem_write), .o_mem_read(mem_read),
    .o_alu_src(alu_src), .o_label_sel(label_sel), .o_jump_sel(jump_sel),
    .o_reg_dest(reg_dest), .o_mem_to_reg(mem_to_reg), .o_halted(halted), .o_err(err),
    .o_state(state)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  // resets the unit with fresh inputs and returns at the mid-point of the first FETCH cycle
  task automatic start(input logic [5:0] op, input logic ia, input logic da);
    instr_op = op; imem_ack = ia; dmem_ack = da; alu_done = 1'b0; branch_taken = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    repeat (2) tick();
    check("rst_state", 32'(state), 0);
    check("rst_outs", 32'({imem_req, dmem_req, ir_write, pc_write, reg_write, mem_write, mem_read,
                          alu_src, label_sel, jump_sel, reg_dest, mem_to_reg, halted, err}), 0);
    start(6'b000000, 1'b1, 1'b0);
    check("r_c1_state", 32'(state), 1);
    check("r_c1_irw", 32'(ir_write), 1);
    check("r_c1_pcw", 32'(pc_write), 1);
    tick();
    check("r_c2_state", 32'(state), 2);
    check("r_c2_irw", 32'(ir_write), 0);
    tick();
    check("r_c3_state", 32'(state), 3);
    tick();
    check("r_c4_state", 32'(state), 5);
    check("r_c4_regw", 32'(reg_write), 1);
    check("r_c4_pcw", 32'(pc_write), 0);
    check("r_c4_dest", 32'(reg_dest), 0);
    tick();
    check("r_c5_state", 32'(state), 1);
    check("r_c5_regw", 32'(reg_write), 0);
    start(6'b010000, 1'b1, 1'b0);
    repeat (2) tick();
    check("ld_c3_rd", 32'(mem_read), 0);
    n_rd = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_rd += int'(mem_read);
    end
    check("ld_rd_cycles", 32'(n_rd), 4);
    check("ld_c7_state", 32'(state), 4);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check("ld_c8_state", 32'(state), 5);
    check("ld_c8_regw", 32'(reg_write), 1);
    check("ld_c8_m2r", 32'(mem_to_reg), 1);
    check("ld_c8_rd", 32'(mem_read), 0);
    start(6'b011000, 1'b1, 1'b1);
    repeat (3) tick();
    check("st_c4_state", 32'(state), 4);
    check("st_c4_memw", 32'(mem_write), 1);
    check("st_c4_regw", 32'(reg_write), 0);
    check("st_c4_alusrc", 32'(alu_src), 1);
    tick();
    check("st_c5_state", 32'(state), 1);
    check("st_c5_regw", 32'(reg_write), 0);
    start(6'b110000, 1'b1, 1'b0);
    branch_taken = 1'b1;
    repeat (2) tick();
    check("bt_c3_state", 32'(state), 3);
    check("bt_c3_pcw", 32'(pc_write), 1);
    check("bt_c3_label", 32'(label_sel), 1);
    tick();
    check("bt_c4_state", 32'(state), 1);
    start(6'b110000, 1'b1, 1'b0);
    repeat (2) tick();
    check("bn_c3_state", 32'(state), 3);
    check("bn_c3_pcw", 32'(pc_write), 0);
    start(6'b100000, 1'b1, 1'b0);
    repeat (3) tick();
    check("jal_c4_state", 32'(state), 5);
    check("jal_c4_regw", 32'(reg_write), 1);
    check("jal_c4_pcw", 32'(pc_write), 1);
    check("jal_c4_dest", 32'(reg_dest), 2);
    check("jal_c4_jsel", 32'(jump_sel), 1);
    start(6'b111111, 1'b1, 1'b0);
    repeat (2) tick();
    check("halt_state", 32'(state), 6);
    check("halt_flag", 32'(halted), 1);
    repeat (5) tick();
    check("halt_sticky", 32'(halted), 1);
    check("halt_noreq", 32'(imem_req), 0);
    start(6'b100101, 1'b1, 1'b0);
    repeat (2) tick();
    check("ill_state", 32'(state), 7);
    check("ill_err", 32'(err), 1);
    repeat (3) tick();
    check("ill_sticky", 32'(err), 1);
    start(6'b000001, 1'b1, 1'b0);
    repeat (3) tick();
    check("long_c4_state", 32'(state), 3);
    check("long_c4_regw", 32'(reg_write), 0);
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    check("long_c5_state", 32'(state), 5);
    check("long_c5_regw", 32'(reg_write), 1);
    start(6'b000000, 1'b0, 1'b0);
    repeat (3) tick();
    check("to_c4_state", 32'(state), 1);
    tick();
    check("to_c5_state", 32'(state), 7);
    check("to_c5_err", 32'(err), 1);
    start(6'b000000, 1'b0, 1'b0);
    repeat (3) tick();
    imem_ack = 1'b1;
    #1;
    check("to_edge_irw", 32'(ir_write), 1);
    tick();
    check("to_edge_state", 32'(state), 2);
    check("to_edge_err", 32'(err), 0);
    start(6'b010000, 1'b1, 1'b0);
    repeat (3) tick();
    check("rm_c4_dreq", 32'(dmem_req), 1);
    rst_n = 1'b0;
    tick();
    check("rm_state", 32'(state), 0);
    check("rm_dreq", 32'(dmem_req), 0);
    rst_n = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
